// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: PWM step count,
// segment bit positions and the active-high hex-to-segment table.
package seg_pkg;

  localparam int SEG_PWM_STEPS = 16;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Bits are G..A, a 1 lights the segment.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus between the core's OUT port (master) and the scan driver (slave).
interface seg_scan_mux_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] NUM;
  logic [DIGITS-1:0]   DP;
  logic [3:0]          BRIGHT;
  logic                BLANK;
  logic [DIGITS-1:0]   DS_EN;
  logic [6:0]          DS_SEG;
  logic                DS_DP;
  logic                FRAME;

  modport master (
    output NUM, DP, BRIGHT, BLANK,
    input  DS_EN, DS_SEG, DS_DP, FRAME
  );

  modport slave (
    input  NUM, DP, BRIGHT, BLANK,
    output DS_EN, DS_SEG, DS_DP, FRAME
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high segment pattern (bits G..A).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment driver with per-digit DP, 16-level PWM and a
// frame-synchronous input latch. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SLOT_CYCLES    = 4096,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input logic          CLK,
  input logic          RST,
  seg_scan_mux_if.slave bus
);

  localparam int STEP  = SLOT_CYCLES / SEG_PWM_STEPS;
  localparam int PRE_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_INV   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] EN_INV   = EN_ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]       pre;
  logic [3:0]             step;
  logic [IDX_W-1:0]       idx;
  logic [DIGITS-1:0][3:0] shadow_num;
  logic [DIGITS-1:0]      shadow_dp;

  // Output registers hold the active-high form; pin polarity is applied on the way out.
  logic [DIGITS-1:0] en_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              frame_q;

  logic              pre_wrap;
  logic              slot_end;
  logic              frame_end;
  logic [3:0]        cur_nibble;
  logic [6:0]        dec_seg;
  logic              digit_blank;
  logic [6:0]        lit_seg;
  logic              lit_dp;
  logic [DIGITS-1:0] en_next;

  assign pre_wrap  = (pre == PRE_LAST);
  assign slot_end  = pre_wrap && (step == 4'hF);
  assign frame_end = slot_end && (idx == IDX_LAST);

  assign cur_nibble = shadow_num[idx];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] lz_blank;
  logic              zero_run;

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (shadow_num[i] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  assign digit_blank = lz_blank[idx];
`else
  assign digit_blank = 1'b0;
`endif

  assign lit_seg = digit_blank ? 7'h00 : dec_seg;
  assign lit_dp  = !digit_blank && shadow_dp[idx];

  // step 15 is never below BRIGHT, so every slot ends with STEP dark cycles.
  assign en_next = ((step < bus.BRIGHT) && !bus.BLANK) ? (DIGITS'(1) << idx) : '0;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (RST) begin
      pre        <= '0;
      step       <= '0;
      idx        <= '0;
      // NOTE: the shadow registers are reset on purpose: the first frame must display zeros.
      shadow_num <= '0;
      shadow_dp  <= '0;
      en_q       <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PRE_W'(1);
      if (pre_wrap) begin
        step <= step + 4'd1;
      end
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (frame_end) begin
        shadow_num <= bus.NUM;
        shadow_dp  <= bus.DP;
      end
      frame_q <= frame_end;
      en_q    <= en_next;
      seg_q   <= lit_seg;
      dp_q    <= lit_dp;
    end
  end

  assign bus.DS_EN  = en_q ^ EN_INV;
  assign bus.DS_SEG = seg_q ^ SEG_INV;
  assign bus.DS_DP  = dp_q ^ DP_INV;
  assign bus.FRAME  = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 32-cycle slots, active-low pins.
// Build with SEG_SCAN_LZB_EN defined to exercise leading-zero blanking.
module tb_seg_scan_mux;

  logic CLK;
  logic RST;

  seg_scan_mux_if #(.DIGITS(4)) bus ();

  seg_scan_mux #(
    .DIGITS         (4),
    .SLOT_CYCLES    (32),
    .SEG_ACTIVE_LOW (1'b1),
    .EN_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Pin patterns (active-low) for the digits used below.
  localparam logic [6:0] PIN_0   = 7'b1000000;
  localparam logic [6:0] PIN_1   = 7'b1111001;
  localparam logic [6:0] PIN_2   = 7'b0100100;
  localparam logic [6:0] PIN_3   = 7'b0110000;
  localparam logic [6:0] PIN_4   = 7'b0011001;
  localparam logic [6:0] PIN_OFF = 7'h7F;

  int vectors     = 0;
  int miscompares = 0;

  int         low_cnt [4];
  int         prefix  [4];
  logic       prefix_open [4];
  logic [6:0] seg_s   [4];
  logic       dp_s    [4];
  int         other_on;
  int         n;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until FRAME is seen; n reports the tick count (300 means timeout).
  task automatic wait_frame(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.FRAME !== 1'b1 && cnt < 300);
  endtask

  // Called right at a frame boundary; after tick j the outputs reflect counter j.
  task automatic scan_frame();
    int d;
    other_on = 0;
    for (int k = 0; k < 4; k++) begin
      low_cnt[k]     = 0;
      prefix[k]      = 0;
      prefix_open[k] = 1'b1;
    end
    for (int j = 0; j < 128; j++) begin
      d = j / 32;
      tick();
      if ((j % 32) == 0) begin
        seg_s[d] = bus.DS_SEG;
        dp_s[d]  = bus.DS_DP;
      end
      if (bus.DS_EN[d] === 1'b0) begin
        low_cnt[d]++;
        if (prefix_open[d]) prefix[d]++;
      end else begin
        prefix_open[d] = 1'b0;
      end
      if ((~bus.DS_EN & ~(4'b0001 << d)) !== 4'b0000) other_on++;
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_d3"}, 32'(seg_s[3]), 32'(e3));
    check({tag, "_d2"}, 32'(seg_s[2]), 32'(e2));
    check({tag, "_d1"}, 32'(seg_s[1]), 32'(e1));
    check({tag, "_d0"}, 32'(seg_s[0]), 32'(e0));
  endtask

  task automatic check_pwm(input string tag, input int exp_low);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_low%0d", tag, k), 32'(low_cnt[k]), 32'(exp_low));
      check($sformatf("%s_pre%0d", tag, k), 32'(prefix[k]), 32'(exp_low));
    end
    check({tag, "_onehot"}, 32'(other_on), 32'd0);
    check({tag, "_period"}, 32'(bus.FRAME), 32'd1);
  endtask

  initial begin
    RST        = 1'b1;
    bus.NUM    = 16'h1234;
    bus.DP     = 4'b0010;
    bus.BRIGHT = 4'd15;
    bus.BLANK  = 1'b0;

    // Reset: all pins inactive, first frame 128 cycles after release.
    repeat (3) tick();
    RST = 1'b0;
    check("rst_en",    32'(bus.DS_EN),  32'hF);
    check("rst_seg",   32'(bus.DS_SEG), 32'(PIN_OFF));
    check("rst_dp",    32'(bus.DS_DP),  32'd1);
    check("rst_frame", 32'(bus.FRAME),  32'd0);
    wait_frame(n);
    check("first_frame", 32'(n), 32'd128);

    // Decode 1234, DP on digit 1, full brightness: 30 lit cycles per slot.
    scan_frame();
    check_digits("dec", PIN_1, PIN_2, PIN_3, PIN_4);
    check("dec_dp1", 32'(dp_s[1]), 32'd0);
    check("dec_dp0", 32'(dp_s[0]), 32'd1);
    check_pwm("b15", 30);

    bus.BRIGHT = 4'd8;
    scan_frame();
    check_pwm("b8", 16);

    bus.BRIGHT = 4'd0;
    scan_frame();
    check_pwm("b0", 0);

    // BLANK raised mid-slot turns enables off on the next register update.
    bus.BRIGHT = 4'd15;
    repeat (5) tick();
    check("pre_blank_en", 32'(bus.DS_EN), 32'hE);
    bus.BLANK = 1'b1;
    tick();
    check("blank_en", 32'(bus.DS_EN), 32'hF);
    bus.BLANK = 1'b0;
    wait_frame(n);
    check("blank_realign", 32'(n), 32'd122);

    // Tear-free latch: NUM changed mid digit-2 slot only shows next frame.
    bus.NUM = 16'h1111;
    wait_frame(n);
    check("tf_load", 32'(n), 32'd128);
    repeat (80) tick();
    check("tf_d2_seg", 32'(bus.DS_SEG), 32'(PIN_1));
    bus.NUM = 16'h2222;
    repeat (17) tick();
    check("tf_d3_seg", 32'(bus.DS_SEG), 32'(PIN_1));
    check("tf_d3_en",  32'(bus.DS_EN),  32'h7);
    wait_frame(n);
    check("tf_frame", 32'(n), 32'd31);
    scan_frame();
    check_digits("tf_new", PIN_2, PIN_2, PIN_2, PIN_2);

    // Leading zeros, with a lit DP on a zero digit.
    bus.NUM = 16'h0012;
    bus.DP  = 4'b0100;
    wait_frame(n);
    check("lz_load", 32'(n), 32'd128);
    scan_frame();
`ifdef SEG_SCAN_LZB_EN
    check_digits("lz12", PIN_OFF, PIN_OFF, PIN_1, PIN_2);
    check("lz12_dp2", 32'(dp_s[2]), 32'd1);
`else
    check_digits("lz12", PIN_0, PIN_0, PIN_1, PIN_2);
    check("lz12_dp2", 32'(dp_s[2]), 32'd0);
`endif

    bus.NUM = 16'h0000;
    wait_frame(n);
    check("lz0_load", 32'(n), 32'd128);
    scan_frame();
`ifdef SEG_SCAN_LZB_EN
    check_digits("lz0", PIN_OFF, PIN_OFF, PIN_OFF, PIN_0);
`else
    check_digits("lz0", PIN_0, PIN_0, PIN_0, PIN_0);
`endif

    // Mid-frame reset at idx 2: outputs inactive, shadows cleared, frame restarts.
    bus.NUM = 16'h1234;
    repeat (70) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mrst_en",    32'(bus.DS_EN),  32'hF);
    check("mrst_seg",   32'(bus.DS_SEG), 32'(PIN_OFF));
    check("mrst_dp",    32'(bus.DS_DP),  32'd1);
    check("mrst_frame", 32'(bus.FRAME),  32'd0);
    tick();
    check("mrst_c0_seg", 32'(bus.DS_SEG), 32'(PIN_0));
    check("mrst_c0_en",  32'(bus.DS_EN),  32'hE);
    wait_frame(n);
    check("mrst_frame_gap", 32'(n), 32'd127);
    tick();
    check("mrst_new_seg", 32'(bus.DS_SEG), 32'(PIN_4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment display driver. It generalises the fixed 4-digit display driver to any number of digits, adds per-digit decimal points and 16-level PWM brightness, and latches its input in a tear-free way. It sits between the core's OUT bus and the board display pins. One instance drives an entire display bank, replacing paired fixed-width instances.

## Interface
Parameters:
- DIGITS, 8: number of multiplexed digits; must be ≥ 2.
- SLOT_CYCLES, 4096: CLK cycles per digit slot; must be a multiple of 16 and ≥ 32.
- SEG_ACTIVE_LOW, 1: 1 means segment and decimal-point pins are driven low to light.
- EN_ACTIVE_LOW, 1: 1 means digit-enable pins are driven low to select a digit.

Ports (one clock; reset is synchronous and active-high):
- CLK, in, 1: system clock.
- RST, in, 1: synchronous active-high reset.
- NUM, in, 4*DIGITS: hex nibbles; nibble i (NUM[4i+3:4i]) goes to digit i; digit 0 is the rightmost.
- DP, in, DIGITS: decimal point for each digit; 1 means lit.
- BRIGHT, in, 4: duty in sixteenths; 0 means dark.
- BLANK, in, 1: forces all digits off.
- DS_EN, out, DIGITS: digit enables.
- DS_SEG, out, 7: segments; bit 0 = A through bit 6 = G.
- DS_DP, out, 1: decimal-point segment.
- FRAME, out, 1: one-cycle pulse at each frame start.

## Operation
Counters and state:
- `pre` counts 0 to STEP-1, where STEP = SLOT_CYCLES/16.
- `step` (4 bits) increments when `pre` wraps.
- `idx` (0 to DIGITS-1) increments when `step` wraps from 15 to 0 and `pre` wraps in the same cycle. `idx` wraps from DIGITS-1 to 0.

Frame latch:
- When `idx` wraps to 0, NUM and DP are captured into shadow registers.
- FRAME is asserted for that one cycle.
- Between frames, changes on NUM and DP have no effect.

Outputs (all registered):
- DS_SEG is the hex decode of shadow nibble `idx`.
- DS_DP is shadow DP[`idx`].
- DS_EN[`idx`] is active iff `step` < BRIGHT and BLANK = 0. All other enables are inactive.
- At most one enable is active in any cycle.
- Since BRIGHT ≤ 15, `step` = 15 is always dark. This gives a guaranteed dead time of STEP cycles around every segment change (anti-ghosting).

Hex decode (active-high form, bits G..A):
- 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
- 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
- 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
- C = 0111001, d = 1011110, E = 1111001, F = 1110001

Polarity: output inversion per SEG_ACTIVE_LOW and EN_ACTIVE_LOW is applied last.

BRIGHT and BLANK are sampled every cycle. They are not shadowed, so they take effect on the next output register update.

## Timing
Reset:
- RST held means that on the next edge `pre` = `step` = `idx` = 0, shadows = 0, and FRAME = 0.
- All DS_EN, DS_SEG and DS_DP pins go to their inactive level.
- RST mid-slot gives the same result; there is no partial-slot completion.

After RST falls:
- First-cycle counters: cycle 0 has `idx` = 0 with the shadow still 0.
- First frame: the first FRAME pulse, and the first NUM capture, occur DIGITS*SLOT_CYCLES cycles after reset release.

Latency and period:
- The registered outputs lag the counters by 1 cycle.
- NUM change to display takes at most DIGITS*SLOT_CYCLES + 1 cycles.
- The frame period is exactly DIGITS*SLOT_CYCLES cycles.

Per-slot timing: an enable is active for BRIGHT*STEP consecutive cycles starting at the slot start, then is inactive for the remainder of the slot.

Simultaneous RST and a frame boundary: reset wins; there is no capture and no FRAME pulse.

## Configuration
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking. Digit i > 0 has its segments and DP forced inactive when every shadow nibble from i up to DIGITS-1 is 0. Digit 0 is always shown. A lit DP on a digit does not prevent that digit from being blanked.
- Undefined: every digit always shows its decoded nibble.

## Structure
- Package seg_pkg holds:
  - the 16-entry hex-to-segment constant table (active-high, G..A);
  - SEG_PWM_STEPS = 16;
  - the segment bit index constants SEG_A through SEG_G.
- One sub-module, seg_hex_decode: a combinational 4-to-7 decoder using the seg_pkg table. It is instantiated once, on the muxed nibble.
- Counters, shadow registers, the LZB mask and output registers live in seg_scan_mux.

## Test plan
Common configuration: DIGITS = 4, SLOT_CYCLES = 32 (STEP = 2), both polarities active-low.
- Reset: RST = 1 for 3 cycles. DS_EN = 4'b1111, DS_SEG = 7'h7F, DS_DP = 1. The first FRAME pulse occurs 128 cycles after release.
- Decode: NUM = 16'h1234, DP = 4'b0010, BRIGHT = 15. After the first FRAME:
  - the digit-0 slot gives DS_SEG = ~7'b1100110 (shows 4);
  - the digit-1 slot gives DS_DP = 0 (lit);
  - each enable is low for 30 of its 32 cycles.
- Brightness: BRIGHT = 0 keeps DS_EN = 4'b1111 forever. BRIGHT = 8 gives 16 low cycles per slot, starting at the slot start. BLANK = 1 mid-slot makes DS_EN go all high one cycle later.
- Tear-free latch: change NUM from 16'h1111 to 16'h2222 in the middle of the digit-2 slot. Digit 3 still shows 1 in that frame, and every digit shows 2 after the next FRAME.
- LZB (macro defined): NUM = 16'h0012 blanks digits 3 and 2 (DS_SEG = 7'h7F). NUM = 16'h0000 shows 0 on digit 0 only. With the macro undefined, NUM = 16'h0012 shows 0, 0, 1, 2.
- Mid-frame reset: RST pulsed for one cycle at `idx` = 2. The next cycle has all outputs inactive and the counters at 0, and no FRAME pulse occurs for the following 128 cycles.
